// File: rtl/ann_io_stream_bridge.sv
// Stream bridge between the narrow pin FIFO handshake and the wide ANN core datapath.
// Optional feature macro: ANN_IO_LOOPBACK_EN adds loopback_en, which routes packed words straight to the output FIFO.
module ann_io_stream_bridge #(
  parameter int DATA_W    = 11,
  parameter int PACK      = 2,
  parameter int IN_DEPTH  = 8,
  parameter int OUT_DEPTH = 8
) (
  input  logic                   io_clk,
  input  logic                   io_rst_n,
  input  logic                   flush,
`ifdef ANN_IO_LOOPBACK_EN
  input  logic                   loopback_en,
`endif
  input  logic                   in_fifo_wenq,
  input  logic [DATA_W-1:0]      in_fifo_wdata,
  output logic                   in_fifo_wfull_n,
  output logic                   core_rd_valid,
  output logic [DATA_W*PACK-1:0] core_rd_data,
  input  logic                   core_rd_ready,
  input  logic                   core_wr_valid,
  input  logic [DATA_W*PACK-1:0] core_wr_data,
  output logic                   core_wr_ready,
  input  logic                   out_fifo_deq,
  output logic [DATA_W-1:0]      out_fifo_rdata,
  output logic                   out_fifo_rempty_n,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int CORE_W = DATA_W * PACK;
  localparam int CNT_W  = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int IAW    = $clog2(IN_DEPTH);
  localparam int OAW    = $clog2(OUT_DEPTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PACK - 1);

  logic lb;
`ifdef ANN_IO_LOOPBACK_EN
  assign lb = loopback_en;
`else
  assign lb = 1'b0;
`endif

  // ---------------- packer ----------------
  logic [CNT_W-1:0]  pack_cnt;
  logic [CORE_W-1:0] pack_buf;
  logic [CORE_W-1:0] pack_word;
  logic              pack_last;
  logic              enq_ok;
  logic              pack_done;
  logic              in_push;
  logic              lb_push;

  // input FIFO state
  logic [CORE_W-1:0] in_mem [IN_DEPTH];
  logic [IAW:0]      in_wr;
  logic [IAW:0]      in_rd;
  logic              in_empty;
  logic              in_full;
  logic              in_pop;

  // output FIFO state
  logic [CORE_W-1:0] out_mem [OUT_DEPTH];
  logic [OAW:0]      out_wr;
  logic [OAW:0]      out_rd;
  logic              out_empty;
  logic              out_full;
  logic              out_push;
  logic              out_pop;
  logic [CORE_W-1:0] out_wdata;
  logic [CNT_W-1:0]  unpack_cnt;
  logic              unpack_last;
  logic              deq_ok;
  logic [CORE_W-1:0] out_head;

  assign pack_last = (pack_cnt == LAST);
  // Only registered occupancy is used, so a same-cycle core pop never raises wfull_n.
  assign in_fifo_wfull_n = !(pack_last && (in_full || (lb && out_full)));
  assign enq_ok    = in_fifo_wenq && in_fifo_wfull_n;
  assign pack_done = enq_ok && pack_last;
  assign in_push   = pack_done && !lb;
  assign lb_push   = pack_done && lb;

  always_comb begin
    pack_word = pack_buf;
    pack_word[int'(pack_cnt)*DATA_W +: DATA_W] = in_fifo_wdata;
  end

  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      pack_cnt <= '0;
      pack_buf <= '0;
    end else if (flush) begin
      pack_cnt <= '0;
      pack_buf <= '0;
    end else if (enq_ok) begin
      pack_buf <= pack_word;
      pack_cnt <= pack_last ? '0 : pack_cnt + CNT_W'(1);
    end
  end

  // ---------------- input FIFO ----------------
  assign in_empty      = (in_wr == in_rd);
  assign in_full       = (in_wr[IAW] != in_rd[IAW]) && (in_wr[IAW-1:0] == in_rd[IAW-1:0]);
  assign core_rd_valid = !in_empty && !lb;
  assign in_pop        = core_rd_valid && core_rd_ready;
  assign core_rd_data  = core_rd_valid ? in_mem[in_rd[IAW-1:0]] : '0;

  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      in_wr <= '0;
      in_rd <= '0;
    end else if (flush) begin
      in_wr <= '0;
      in_rd <= '0;
    end else begin
      if (in_push) in_wr <= in_wr + 1'b1;
      if (in_pop)  in_rd <= in_rd + 1'b1;
    end
  end

  always_ff @(posedge io_clk) begin
    if (in_push) in_mem[in_wr[IAW-1:0]] <= pack_word;
  end

  // ---------------- output FIFO and unpacker ----------------
  assign out_empty   = (out_wr == out_rd);
  assign out_full    = (out_wr[OAW] != out_rd[OAW]) && (out_wr[OAW-1:0] == out_rd[OAW-1:0]);
  assign core_wr_ready = !out_full;
  assign unpack_last = (unpack_cnt == LAST);
  assign deq_ok      = out_fifo_deq && !out_empty;
  assign out_pop     = deq_ok && unpack_last;
  // A push into a full FIFO still lands when the last pin word of the head leaves the same cycle.
  assign out_push    = ((core_wr_valid && !lb) || lb_push) && (!out_full || out_pop);
  assign out_wdata   = lb ? pack_word : core_wr_data;

  assign out_fifo_rempty_n = !out_empty;
  assign out_head          = out_mem[out_rd[OAW-1:0]];
  assign out_fifo_rdata    = out_empty ? '0 : out_head[int'(unpack_cnt)*DATA_W +: DATA_W];

  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      out_wr     <= '0;
      out_rd     <= '0;
      unpack_cnt <= '0;
    end else if (flush) begin
      out_wr     <= '0;
      out_rd     <= '0;
      unpack_cnt <= '0;
    end else begin
      if (out_push) out_wr <= out_wr + 1'b1;
      if (out_pop)  out_rd <= out_rd + 1'b1;
      if (deq_ok)   unpack_cnt <= unpack_last ? '0 : unpack_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge io_clk) begin
    if (out_push) out_mem[out_wr[OAW-1:0]] <= out_wdata;
  end

  // ---------------- sticky error flags ----------------
  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (in_fifo_wenq && !in_fifo_wfull_n) overflow  <= 1'b1;
      if (out_fifo_deq && out_empty)        underflow <= 1'b1;
    end
  end

endmodule
